// File: rtl/demux_1x2_pkg.sv
// Shared encodings for the 1-to-2 burst demux.
// FSM states and output-port identifiers.
package demux_1x2_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic PORT_OUT1 = 1'b0;
  localparam logic PORT_OUT2 = 1'b1;

endpackage

// File: rtl/demux_1x2_sched_if.sv
// Bundle for the burst demux: one valid/ready input, two outputs.
// master = producer/consumer side, slave = the demux.
interface demux_1x2_sched_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              mode;
  logic              s;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [DATA_W-1:0] out2_data;
  logic              cur_port;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output mode, s, in_valid, in_data,
    output out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data,
    input  out2_valid, out2_data,
    input  cur_port, beat_cnt
  );

  modport slave (
    input  mode, s, in_valid, in_data,
    input  out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data,
    output out2_valid, out2_data,
    output cur_port, beat_cnt
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register.
// Ports: clk, rst_n, load, load_data, ready -> valid, data.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_1x2_sched.sv
// Burst sequencer steering one valid/ready stream to two slots.
// Ports: clk, rst_n, bus (slave: input stream, out1/out2, status).
module demux_1x2_sched
  import demux_1x2_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  demux_1x2_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam bit SINGLE = (BURST_LEN == 1);

  state_e           state_q, state_d;
  logic             port_q, port_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic target;
  logic tgt_valid;
  logic tgt_ready;
  logic rdy;
  logic accept;
  logic load1, load2;
  logic v1, v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_OUT1;
      rr_q    <= PORT_OUT1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          port_d = target;
          // A one-beat burst completes on its
          // own accept and never leaves IDLE.
          if (SINGLE) begin
            rr_d = ~target;
          end else begin
            cnt_d   = ONE_CNT;
            state_d = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            rr_d    = ~port_q;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Target is live in IDLE so the first beat
  // of a new burst goes out without a bubble.
  always_comb begin
    target = port_q;
    if (state_q == ST_IDLE)
      target = bus.mode ? rr_q : bus.s;
    tgt_valid = (target == PORT_OUT2) ? v2 : v1;
    tgt_ready = (target == PORT_OUT2)
              ? bus.out2_ready
              : bus.out1_ready;
    rdy    = !tgt_valid || tgt_ready;
    accept = bus.in_valid && rdy;
    load1  = accept && (target == PORT_OUT1);
    load2  = accept && (target == PORT_OUT2);
  end

  demux_out_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (bus.in_data),
    .ready     (bus.out1_ready),
    .valid     (v1),
    .data      (bus.out1_data)
  );

  demux_out_slot #(.DATA_W(DATA_W)) u_slot2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load2),
    .load_data (bus.in_data),
    .ready     (bus.out2_ready),
    .valid     (v2),
    .data      (bus.out2_data)
  );

  assign bus.in_ready   = rdy;
  assign bus.out1_valid = v1;
  assign bus.out2_valid = v2;
  assign bus.cur_port   = target;
  assign bus.beat_cnt   = cnt_q;

endmodule

// File: doc/demux_1x2_sched.md
Name: demux_1x2_sched

Overview:
- Sequencing controller for the 1-to-2 demux datapath. Accepts one valid/ready input stream and steers bursts of BURST_LEN beats to out1 or out2.
- Target selection is either fixed by a select input (mode 0) or alternating round-robin per burst (mode 1).
- Each output has a one-entry registered slot, so the two consumers drain independently.
- Sits between a single producer and two downstream consumers; replaces the bare combinational demux wherever backpressure matters.

Parameters:
- DATA_W, 8, data width in bits.
- BURST_LEN, 4, beats routed to one output before the target may change. Legal range 1..256.
- CNT_W, 8, width of the beat counter. Must satisfy 2^CNT_W >= BURST_LEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = select-driven, 1 = round-robin per burst.
- s  in  1  target select in mode 0: 0 = out1, 1 = out2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  input beat data.
- out1_valid  out  1  out1 slot holds a beat.
- out1_ready  in  1  out1 consumer accepts.
- out1_data  out  DATA_W  out1 beat data.
- out2_valid  out  1  out2 slot holds a beat.
- out2_ready  in  1  out2 consumer accepts.
- out2_data  out  DATA_W  out2 beat data.
- cur_port  out  1  current or next burst target: 0 = out1, 1 = out2.
- beat_cnt  out  CNT_W  beats accepted so far in the current burst.

Behaviour:
- Reset (async, rst_n=0):
  - out1_valid = out2_valid = 0, out1_data = out2_data = 0.
  - state = IDLE, cur_port = 0, beat_cnt = 0, rr_ptr = 0.
  - Beats in flight are discarded.
  - Deassertion is sampled on the next rising clk.
- FSM has two states, IDLE and BURST.
- IDLE:
  - Target is combinational: s in mode 0, rr_ptr in mode 1. cur_port shows this target.
  - On accept: latch target into cur_port, beat_cnt <= 1, go to BURST.
  - If BURST_LEN == 1: stay in IDLE, beat_cnt stays 0, rr_ptr toggles in mode 1.
- BURST:
  - Target is frozen at cur_port; changes on s or mode are ignored.
  - Each accept increments beat_cnt.
  - The accept that makes the burst count reach BURST_LEN: beat_cnt <= 0, go to IDLE, rr_ptr <= ~cur_port. rr_ptr updates only on burst completion, in either mode.
  - No in_valid for any number of cycles: hold state. A burst never times out.
- in_ready = !target_valid | target_ready, where target is the selected slot.
  - Combinational from the out ready signals; no combinational path from in_valid.
  - The non-target output never gates in_ready.
- Output slot, per output:
  - Load on accept to that port: valid <= 1, data <= in_data.
  - Drain when valid & ready and no load: valid <= 0; data holds its last value.
  - Load and drain in the same cycle: valid stays 1, data is replaced.
- Latency: a beat accepted at edge N is visible on outX at edge N (registered), one cycle after presentation.
- Throughput: 1 beat/cycle while the target consumer holds ready=1.
- Simultaneous events:
  - The non-target slot drains independently in the same cycle as a load to the target.
  - A mode change in the same cycle as a burst-completing accept affects the next burst only.
- Back-to-back bursts: the IDLE cycle after a burst costs no bubble. in_ready in IDLE is evaluated against the newly selected target.
- Input data is never duplicated or dropped.

Decomposition:
- Shared package demux_1x2_pkg holds:
  - state encodings: ST_IDLE = 1'b0, ST_BURST = 1'b1;
  - port encodings: PORT_OUT1 = 1'b0, PORT_OUT2 = 1'b1.
- One sub-module, demux_out_slot: a one-entry valid/ready register with ports clk, rst_n, load, load_data, ready, valid, data. Instantiated twice.
- FSM, counter and rr_ptr stay in the top module.

Test Plan:
- Mode 0, s=0, BURST_LEN=4, in_valid held with data 0x10..0x13, out1_ready=1 → out1 shows 0x10..0x13 on consecutive cycles, out2_valid stays 0, beat_cnt reads 1,2,3,0.
- Mode 0, s toggles to 1 after the 2nd beat of a burst → beats 3–4 still go to out1; the next burst (0x20..0x23) goes to out2 with cur_port=1.
- Mode 1, 12 beats 0x00..0x0B, both readies=1 → out1 gets 0x00–03 and 0x08–0B, out2 gets 0x04–07, with no idle cycle between bursts.
- Mode 0, s=1, out2_ready=0 with the slot full → in_ready=0 and data 0x55 is held at the input. Raise out2_ready → 0x55 is accepted; out2 presents the old beat then 0x55. out1 is unaffected.
- rst_n pulled low mid-burst (beat_cnt=2, out1_valid=1) → all valids and beat_cnt drop to 0 immediately without a clock, and the first burst after release goes to out1 in mode 1.
- BURST_LEN=1, mode 1, 4 beats 0xA0..0xA3 → targets alternate out1, out2, out1, out2, and beat_cnt stays 0.
